ext_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate sign-extender, for the pipelined/multi-cycle CPU datapath.
- Handles both immediate extension (sign, zero, LUI) and load-data extension (byte/halfword, signed/unsigned, offset-selected) in one unit.
- Has STAGES register stages with valid/stall/flush control.
- Flags illegal modes and misaligned halfwords, and keeps a saturating error count.

---
 rtl/ext_unit_pipe.sv | 153 +++++++++++++++
 tb/tb_ext_unit_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ext_unit_pipe
// Description : Pipelined immediate / load-data extension unit. Stage 0 is
//               combinational (sign/zero/LUI immediate extension and
//               byte/halfword load extraction). Its result is captured into a
//               STAGES-deep valid/stall/flush pipeline. The unit flags
//               illegal modes and misaligned halfwords, and keeps a
//               saturating count of flagged results.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_unit_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int ERRC_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    mode,
  input  logic [IMM_W-1:0]              imm,
  input  logic [DATA_W-1:0]             src_data,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_err,
  output logic [ERRC_W-1:0]             err_cnt
);

  localparam int c_off_w = $clog2(DATA_W/8);
  localparam int c_last  = STAGES - 1;

  localparam logic [2:0] c_mode_sext = 3'd0;
  localparam logic [2:0] c_mode_zext = 3'd1;
  localparam logic [2:0] c_mode_lui  = 3'd2;
  localparam logic [2:0] c_mode_lb   = 3'd3;
  localparam logic [2:0] c_mode_lbu  = 3'd4;
  localparam logic [2:0] c_mode_lh   = 3'd5;
  localparam logic [2:0] c_mode_lhu  = 3'd6;

  // Stage-0 operand selection: the addressed byte and the addressed halfword.
  // The halfword index ignores byte_off[0]; misalignment is flagged separately.
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_data;
  logic              w_err;

  assign w_byte = src_data[{byte_off, 3'b000} +: 8];
  assign w_half = src_data[{byte_off[c_off_w-1:1], 4'b0000} +: 16];

  // Pipeline stage state; index 0 is the first register stage, c_last feeds out_*.
  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [DATA_W-1:0] data_q  [STAGES];
  logic [DATA_W-1:0] data_d  [STAGES];
  logic              err_q   [STAGES];
  logic              err_d   [STAGES];
  logic [ERRC_W-1:0] err_cnt_q;
  logic [ERRC_W-1:0] err_cnt_d;

  // Stage-0 extension function; illegal combinations return zero data with err set.
  always_comb begin
    w_data = '0;
    w_err  = 1'b0;
    case (mode)
      c_mode_sext: w_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      c_mode_zext: w_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      c_mode_lui:  w_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      c_mode_lb:   w_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      c_mode_lbu:  w_data = {{(DATA_W-8){1'b0}}, w_byte};
      c_mode_lh: begin
        if (byte_off[0]) begin
          w_err = 1'b1;
        end else begin
          w_data = {{(DATA_W-16){w_half[15]}}, w_half};
        end
      end
      c_mode_lhu: begin
        if (byte_off[0]) begin
          w_err = 1'b1;
        end else begin
          w_data = {{(DATA_W-16){1'b0}}, w_half};
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Next-state of the pipeline: flush kills all valids (and wins over stall),
  // stall holds everything, otherwise every stage shifts forward by one.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      valid_d[s] = valid_q[s];
      data_d[s]  = data_q[s];
      err_d[s]   = err_q[s];
    end
    if (flush) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_d[s] = 1'b0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      data_d[0]  = w_data;
      err_d[0]   = w_err;
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
        err_d[s]   = err_q[s-1];
      end
    end
  end

  // Error counter advances only when a flagged result leaves the last stage,
  // so a result held by stall is counted once; it saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_q[c_last] && err_q[c_last] && !stall && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset; reset discards all in-flight entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        err_q[s]   <= 1'b0;
      end
      err_cnt_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= valid_d[s];
        data_q[s]  <= data_d[s];
        err_q[s]   <= err_d[s];
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  // Output data and error are qualified by valid so stale contents never leak.
  assign in_ready  = ~stall;
  assign out_valid = valid_q[c_last];
  assign out_data  = valid_q[c_last] ? data_q[c_last] : '0;
  assign out_err   = valid_q[c_last] & err_q[c_last];
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_unit_pipe
// Description : Scoreboard bench for ext_unit_pipe. Directed cases plus
//               randomized traffic with stall/flush; expected results come
//               from an arithmetic reference model and are queued at accept
//               time, then popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_unit_pipe;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;
  localparam int STAGES = 2;
  localparam int ERRC_W = 8;
  localparam int C_SAT  = (1 << ERRC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        mode = '0;
  logic [IMM_W-1:0]  imm = '0;
  logic [DATA_W-1:0] src_data = '0;
  logic [1:0]        byte_off = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [ERRC_W-1:0] err_cnt;

  ext_unit_pipe #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W),
    .STAGES(STAGES),
    .ERRC_W(ERRC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .imm      (imm),
    .src_data (src_data),
    .byte_off (byte_off),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          act      = 0;
  int          exp_cnt  = 0;
  logic [31:0] stim_d   = '0;
  logic        stim_e   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: result as plain integer arithmetic; bit 32 is the error flag.
  function automatic logic [32:0] ref_ext(input int m, input int i, input logic [31:0] s, input int o);
    longint v;
    longint b;
    longint h;
    logic   e;
    b = (s >> (8 * o)) & 32'hFF;
    h = (s >> (16 * (o / 2))) & 32'hFFFF;
    v = 0;
    e = 1'b0;
    case (m)
      0: begin v = i; if (v >= 32768) v = v - 65536; end
      1: v = i;
      2: v = longint'(i) * 65536;
      3: begin v = b; if (v >= 128) v = v - 256; end
      4: v = b;
      5: begin
        if (o % 2 != 0) e = 1'b1;
        else begin v = h; if (v >= 32768) v = v - 65536; end
      end
      6: begin
        if (o % 2 != 0) e = 1'b1;
        else v = h;
      end
      default: e = 1'b1;
    endcase
    if (v < 0) v = v + 64'h1_0000_0000;
    return {e, v[31:0]};
  endfunction

  // Monitor: compares the presented output against the scoreboard head and
  // models the upcoming edge (pop on leave, clear on flush, push on accept).
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      exp_cnt = 0;
    end else begin
      check("in_ready", in_ready, !stall);
      check("err_cnt", err_cnt, exp_cnt);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", out_data, 64'hDEAD_0000_0000);
        end else begin
          check("out_data", out_data, sbq[0].d);
          check("out_err", out_err, sbq[0].e);
          check("latency", act, sbq[0].t + STAGES);
          if (!stall) begin
            if (sbq[0].e && exp_cnt < C_SAT) exp_cnt++;
            void'(sbq.pop_front());
          end
        end
      end else begin
        check("idle_zero", {out_data, out_err}, '0);
        if (sbq.size() > 0 && act >= sbq[0].t + STAGES)
          check("missing_output", out_valid, 1'b1);
      end
      if (flush) sbq.delete();
      if (in_valid && !stall && !flush) sbq.push_back('{d: stim_d, e: stim_e, t: act});
      if (!stall) act++;
    end
  end

  task automatic send(input logic [2:0] m, input logic [15:0] i, input logic [31:0] s,
                      input logic [1:0] o, input logic [31:0] ed, input logic ee);
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    mode = m; imm = i; src_data = s; byte_off = o;
    stim_d = ed; stim_e = ee;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input logic iv, input logic st, input logic fl, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = iv; stall = st; flush = fl;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic rand_cycle();
    logic [32:0] r;
    in_valid = ($urandom_range(0, 3) != 0);
    mode     = 3'($urandom_range(0, 7));
    imm      = 16'($urandom);
    src_data = $urandom;
    byte_off = 2'($urandom_range(0, 3));
    stall    = ($urandom_range(0, 4) == 0);
    flush    = ($urandom_range(0, 19) == 0);
    r = ref_ext(int'(mode), int'(imm), src_data, int'(byte_off));
    stim_d = r[31:0];
    stim_e = r[32];
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1);

    // Immediate modes, back to back
    send(3'd0, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
    send(3'd1, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
    send(3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0);
    // Loads
    send(3'd3, 16'h0, 32'h80F17F02, 2'd2, 32'hFFFFFFF1, 1'b0);
    send(3'd4, 16'h0, 32'h80F17F02, 2'd2, 32'h000000F1, 1'b0);
    send(3'd5, 16'h0, 32'h80F17F02, 2'd2, 32'hFFFF80F1, 1'b0);
    send(3'd6, 16'h0, 32'h80F17F02, 2'd0, 32'h00007F02, 1'b0);
    // Errors
    send(3'd5, 16'h0, 32'h80F17F02, 2'd1, 32'h0, 1'b1);
    send(3'd7, 16'h1234, 32'h80F17F02, 2'd0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4);
    check("err_cnt_two", err_cnt, 8'd2);
    for (int k = 0; k < 300; k++) send(3'd7, 16'(k), 32'h0, 2'd0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4);
    check("err_cnt_sat", err_cnt, 8'd255);

    // Stall with entry in the first stage, then with entry presented
    send(3'd0, 16'h0005, 32'h0, 2'd0, 32'h00000005, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3);
    send(3'd0, 16'h0005, 32'h0, 2'd0, 32'h00000005, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3);

    // Flush with stall and a valid input in the same cycle
    send(3'd1, 16'hAAAA, 32'h0, 2'd0, 32'h0000AAAA, 1'b0);
    send(3'd1, 16'hBBBB, 32'h0, 2'd0, 32'h0000BBBB, 1'b0);
    mode = 3'd1; imm = 16'hCCCC; stim_d = 32'h0000CCCC; stim_e = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1);
    check("flush_out_valid", out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4);

    // Asynchronous reset mid-stream
    send(3'd1, 16'h1111, 32'h0, 2'd0, 32'h00001111, 1'b0);
    send(3'd1, 16'h2222, 32'h0, 2'd0, 32'h00002222, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_err_cnt", err_cnt, 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(3'd2, 16'h0001, 32'h0, 2'd0, 32'h00010000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3);

    // Randomized traffic
    for (int k = 0; k < 600; k++) rand_cycle();
    step(1'b0, 1'b0, 1'b0, 1);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    check("drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
